// File: rtl/kt_pkg.sv
// Shared definitions for the response/telemetry TX scheduler.
//   sched_state_t : byte scheduler states
//   ACK_DONE / ACK_BUSY : acknowledge byte values from the command processor
//   TELE_HDR_DEF : default telemetry frame header byte
package kt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        T_HDR,
        T_HI,
        T_LO
    } sched_state_t;

    localparam logic [7:0] ACK_DONE     = 8'hA5;
    localparam logic [7:0] ACK_BUSY     = 8'h5A;
    localparam logic [7:0] TELE_HDR_DEF = 8'hC3;

endpackage

// File: rtl/tele_div.sv
// Telemetry divider: counts heading_rdy pulses and, every TELE_DIV pulses,
// snapshots the heading and raises tele_pend.
//   clk, rst_n   : clock, async active-low reset
//   tele_en      : level enable; low clears the divider and any pending frame
//   heading      : signed heading sample
//   heading_rdy  : 1-cycle pulse, heading valid
//   clr          : scheduler consumed the pending frame
//   tele_pend    : a frame is waiting to be sent
//   hd_reg       : latest heading snapshot
module tele_div #(
    parameter int unsigned TELE_DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tele_en,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        clr,
    output logic        tele_pend,
    output logic [11:0] hd_reg
);

    localparam logic [7:0] LAST = 8'(TELE_DIV - 1);

    logic [7:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            tele_pend <= 1'b0;
            hd_reg    <= '0;
        end else if (!tele_en) begin
            div_cnt   <= '0;
            tele_pend <= 1'b0;
        end else begin
            if (clr)
                tele_pend <= 1'b0;
            // A fresh snapshot in the same cycle as a clear queues a new frame.
            if (heading_rdy) begin
                if (div_cnt == LAST) begin
                    div_cnt   <= '0;
                    hd_reg    <= heading;
                    tele_pend <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/resp_tx_sched.sv
// Shares the UART TX byte channel between command acknowledges and a
// periodic 3-byte heading telemetry frame (header, sign-extended high
// nibble, low byte). Acks win at frame boundaries; frames are never split.
//   clk, rst_n   : clock, async active-low reset
//   ack_req      : 1-cycle pulse, send ack_byte
//   ack_byte     : ack value, sampled on ack_req
//   tele_en      : telemetry enable level
//   heading      : signed 12-bit heading
//   heading_rdy  : 1-cycle pulse, heading valid
//   tx_done      : UART byte finished (level)
//   trmt         : 1-cycle pulse, start transmit of tx_data
//   tx_data      : byte being transmitted
//   ack_sent     : 1-cycle pulse when the ack byte completes
//   ack_ovf      : sticky, ack_req arrived with an ack already pending
//   busy         : scheduler not IDLE
module resp_tx_sched
    import kt_pkg::*;
#(
    parameter int unsigned TELE_DIV = 16,
    parameter logic [7:0]  TELE_HDR = TELE_HDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ack_req,
    input  logic [7:0]  ack_byte,
    input  logic        tele_en,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        tx_done,
    output logic        trmt,
    output logic [7:0]  tx_data,
    output logic        ack_sent,
    output logic        ack_ovf,
    output logic        busy
);

    sched_state_t state, state_nx;

    logic        ack_pend, ack_pend_nx;
    logic [7:0]  ack_reg, ack_reg_nx;
    logic        ack_ovf_nx;
    logic        trmt_nx;
    logic [7:0]  tx_data_nx;
    logic        ack_sent_nx;
    logic        tele_clr;
    logic        tele_pend;
    logic [11:0] hd_reg;
    logic        byte_done;

    tele_div #(
        .TELE_DIV (TELE_DIV)
    ) u_tele_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .tele_en     (tele_en),
        .heading     (heading),
        .heading_rdy (heading_rdy),
        .clr         (tele_clr),
        .tele_pend   (tele_pend),
        .hd_reg      (hd_reg)
    );

    // tx_done still reflects the previous byte while trmt is high.
    assign byte_done = tx_done && !trmt;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx    = state;
        trmt_nx     = 1'b0;
        tx_data_nx  = tx_data;
        ack_sent_nx = 1'b0;
        ack_pend_nx = ack_pend;
        ack_reg_nx  = ack_reg;
        ack_ovf_nx  = ack_ovf;
        tele_clr    = 1'b0;

        if (ack_req) begin
            ack_pend_nx = 1'b1;
            ack_reg_nx  = ack_byte;
            if (ack_pend)
                ack_ovf_nx = 1'b1;
        end

        unique case (state)
            IDLE: begin
                // A request arriving this cycle is sent directly so trmt
                // follows ack_req by one cycle.
                if (ack_req || ack_pend) begin
                    state_nx    = ACK;
                    trmt_nx     = 1'b1;
                    tx_data_nx  = ack_req ? ack_byte : ack_reg;
                    ack_pend_nx = 1'b0;
                end else if (tele_pend) begin
                    state_nx   = T_HDR;
                    trmt_nx    = 1'b1;
                    tx_data_nx = TELE_HDR;
                    tele_clr   = 1'b1;
                end
            end
            ACK: begin
                if (byte_done) begin
                    state_nx    = IDLE;
                    ack_sent_nx = 1'b1;
                end
            end
            T_HDR: begin
                if (byte_done) begin
                    state_nx   = T_HI;
                    trmt_nx    = 1'b1;
                    tx_data_nx = {{4{hd_reg[11]}}, hd_reg[11:8]};
                end
            end
            T_HI: begin
                if (byte_done) begin
                    state_nx   = T_LO;
                    trmt_nx    = 1'b1;
                    tx_data_nx = hd_reg[7:0];
                end
            end
            T_LO: begin
                if (byte_done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            trmt     <= 1'b0;
            tx_data  <= '0;
            ack_sent <= 1'b0;
            ack_pend <= 1'b0;
            ack_reg  <= '0;
            ack_ovf  <= 1'b0;
        end else begin
            state    <= state_nx;
            trmt     <= trmt_nx;
            tx_data  <= tx_data_nx;
            ack_sent <= ack_sent_nx;
            ack_pend <= ack_pend_nx;
            ack_reg  <= ack_reg_nx;
            ack_ovf  <= ack_ovf_nx;
        end
    end

endmodule

// File: tb/tb_resp_tx_sched.sv
// Testbench for resp_tx_sched: a transaction-level reference model pushes
// expected bytes / ack completions into queues; a negedge monitor pops and
// compares whenever the DUT pulses trmt or ack_sent.
module tb_resp_tx_sched;
    import kt_pkg::*;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ack_req = 1'b0;
    logic [7:0]  ack_byte = '0;
    logic        tele_en = 1'b0;
    logic [11:0] heading = '0;
    logic        heading_rdy = 1'b0;
    logic        tx_done = 1'b1;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        ack_sent;
    logic        ack_ovf;
    logic        busy;

    resp_tx_sched #(
        .TELE_DIV (DIV),
        .TELE_HDR (TELE_HDR_DEF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ack_req     (ack_req),
        .ack_byte    (ack_byte),
        .tele_en     (tele_en),
        .heading     (heading),
        .heading_rdy (heading_rdy),
        .tx_done     (tx_done),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .ack_sent    (ack_sent),
        .ack_ovf     (ack_ovf),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned n_trmt = 0;
    int unsigned n_ack = 0;

    typedef struct {
        logic [7:0]  b;
        int unsigned c;
    } exp_t;

    exp_t        byte_q[$];
    int unsigned sent_q[$];
    logic [7:0]  last_b = '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // One "transaction" is either an ack byte or a 3-byte frame; m_left
    // counts bytes still to start after the current one.
    bit          m_active, m_is_ack, m_fresh, m_ack_pend, m_ovf, m_tele;
    int          m_left;
    logic [7:0]  m_ack_reg, m_cur;
    logic [11:0] m_hd, hd_pre;
    int unsigned m_cnt;
    bit          ack_go, tele_go;

    function automatic logic [7:0] hi_byte(input logic [11:0] h);
        int sv;
        sv = int'(signed'(h));
        return 8'((sv >>> 8) & 255);
    endfunction

    function automatic logic [7:0] lo_byte(input logic [11:0] h);
        return 8'(int'(h) % 256);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_is_ack = 0; m_fresh = 0; m_ack_pend = 0;
            m_ovf = 0; m_tele = 0; m_left = 0; m_ack_reg = '0;
            m_hd = '0; m_cnt = 0;
            byte_q.delete();
            sent_q.delete();
        end else begin
            cyc++;
            ack_go = 0;
            tele_go = 0;
            hd_pre = m_hd;
            if (!m_active) begin
                if (ack_req || m_ack_pend) begin
                    ack_go = 1; m_is_ack = 1; m_left = 0;
                    m_cur = ack_req ? ack_byte : m_ack_reg;
                end else if (m_tele) begin
                    tele_go = 1; m_is_ack = 0; m_left = 2;
                    m_cur = TELE_HDR_DEF;
                end
                if (ack_go || tele_go) begin
                    m_active = 1;
                    m_fresh = 1;
                    byte_q.push_back('{m_cur, cyc});
                end
            end else if (m_fresh) begin
                m_fresh = 0;
            end else if (tx_done) begin
                if (m_left > 0) begin
                    m_cur = (m_left == 2) ? hi_byte(hd_pre) : lo_byte(hd_pre);
                    m_left--;
                    m_fresh = 1;
                    byte_q.push_back('{m_cur, cyc});
                end else begin
                    m_active = 0;
                    if (m_is_ack) sent_q.push_back(cyc);
                end
            end
            if (ack_req) begin
                if (m_ack_pend) m_ovf = 1;
                m_ack_pend = 1;
                m_ack_reg = ack_byte;
            end
            if (ack_go) m_ack_pend = 0;
            if (tele_go) m_tele = 0;
            if (!tele_en) begin
                m_cnt = 0;
                m_tele = 0;
            end else if (heading_rdy) begin
                if (m_cnt == DIV - 1) begin
                    m_cnt = 0;
                    m_hd = heading;
                    m_tele = 1;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    exp_t        e;
    int unsigned ec;

    always @(negedge clk) begin
        if (rst_n) begin
            if (trmt) begin
                n_trmt++;
                if (byte_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_trmt: got data %0h, expected no byte (cycle %0d)", tx_data, cyc);
                end else begin
                    e = byte_q.pop_front();
                    chk("tx_data", tx_data, e.b);
                    chk("trmt_cycle", cyc, e.c);
                    last_b = e.b;
                end
            end else if (busy) begin
                chk("tx_data_hold", tx_data, last_b);
            end
            if (ack_sent) begin
                n_ack++;
                if (sent_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack_sent: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    ec = sent_q.pop_front();
                    chk("ack_sent_cycle", cyc, ec);
                end
            end
            chk("ack_ovf", ack_ovf, m_ovf);
            chk("busy", busy, m_active);
        end
    end

    // ---------------- UART model ----------------
    int  uart_cnt = 0;
    bit  uart_clr = 0;
    bit  uart_hang = 0;
    bit  uart_rand = 0;
    int  uart_dly = 20;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_done = 1'b1;
                uart_cnt = 0;
                uart_clr = 0;
            end else begin
                if (uart_clr) begin
                    tx_done = 1'b0;
                    uart_clr = 0;
                end
                if (trmt) begin
                    uart_clr = 1;
                    uart_cnt = uart_rand ? int'($urandom_range(2, 8)) : uart_dly;
                end else if (uart_cnt > 0 && !uart_hang) begin
                    uart_cnt--;
                    if (uart_cnt == 0) tx_done = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack(input logic [7:0] b);
        ack_req = 1'b1;
        ack_byte = b;
        @(negedge clk);
        ack_req = 1'b0;
    endtask

    task automatic hd_pulses(input int n, input logic [11:0] h);
        for (int i = 0; i < n; i++) begin
            heading = h;
            heading_rdy = 1'b1;
            @(negedge clk);
            heading_rdy = 1'b0;
            tick(2);
        end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (!m_active && !m_ack_pend && !m_tele && byte_q.size() == 0 && sent_q.size() == 0)
                quiet++;
            else
                quiet = 0;
        end
        if (quiet < 3) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles, expected idle", nm, n);
        end
    endtask

    task automatic wait_trmt(input string nm, input int unsigned target, input int budget);
        int n = 0;
        while (n_trmt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_trmt < target) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d trmt, expected %0d", nm, n_trmt, target);
        end
    endtask

    int unsigned t0, a0;

    initial begin
        tick(3);
        #1;
        chk("rst_trmt", trmt, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_ack_sent", ack_sent, 0);
        chk("rst_ack_ovf", ack_ovf, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // 1: single ack
        t0 = n_trmt; a0 = n_ack;
        pulse_ack(ACK_DONE);
        wait_idle("t1", 200);
        tick(20);
        chk("t1_trmt_count", n_trmt - t0, 1);
        chk("t1_ack_count", n_ack - a0, 1);
        chk("t1_busy", busy, 0);

        // 2: one telemetry frame
        tele_en = 1'b1;
        t0 = n_trmt; a0 = n_ack;
        hd_pulses(3, 12'h111);
        hd_pulses(1, 12'hF3A);
        wait_idle("t2", 300);
        chk("t2_trmt_count", n_trmt - t0, 3);
        chk("t2_ack_count", n_ack - a0, 0);

        // 3: ack during T_HI waits for frame end
        uart_dly = 6;
        t0 = n_trmt; a0 = n_ack;
        hd_pulses(3, 12'h222);
        hd_pulses(1, 12'h07F);
        wait_trmt("t3", t0 + 2, 200);
        tick(1);
        pulse_ack(ACK_BUSY);
        wait_idle("t3", 300);
        chk("t3_trmt_count", n_trmt - t0, 4);
        chk("t3_ack_count", n_ack - a0, 1);

        // 4: ack_req coincident with the frame-triggering heading_rdy
        t0 = n_trmt;
        hd_pulses(3, 12'h333);
        heading = 12'h8C1;
        heading_rdy = 1'b1;
        ack_req = 1'b1;
        ack_byte = ACK_DONE;
        @(negedge clk);
        heading_rdy = 1'b0;
        ack_req = 1'b0;
        wait_idle("t4", 300);
        chk("t4_trmt_count", n_trmt - t0, 4);

        // 5: two acks while a frame is in progress -> overflow, last one wins
        t0 = n_trmt; a0 = n_ack;
        hd_pulses(4, 12'h456);
        wait_trmt("t5", t0 + 1, 200);
        pulse_ack(ACK_DONE);
        tick(2);
        pulse_ack(ACK_BUSY);
        wait_idle("t5", 300);
        chk("t5_ack_ovf", ack_ovf, 1);
        chk("t5_trmt_count", n_trmt - t0, 4);
        chk("t5_ack_count", n_ack - a0, 1);
        tick(10);
        chk("t5_ack_ovf_sticky", ack_ovf, 1);

        // 6: reset mid-frame with the UART stalled
        uart_hang = 1;
        t0 = n_trmt;
        hd_pulses(4, 12'h789);
        wait_trmt("t6", t0 + 1, 200);
        tick(3);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_trmt", trmt, 0);
        chk("t6_rst_tx_data", tx_data, 0);
        chk("t6_rst_ack_sent", ack_sent, 0);
        chk("t6_rst_ack_ovf", ack_ovf, 0);
        chk("t6_rst_busy", busy, 0);
        tick(3);
        uart_hang = 0;
        tele_en = 1'b0;
        rst_n = 1'b1;
        t0 = n_trmt;
        tick(1000);
        chk("t6_quiet_trmt", n_trmt - t0, 0);

        // tele_en drop mid-frame: frame completes, nothing further queued
        tele_en = 1'b1;
        t0 = n_trmt;
        hd_pulses(4, 12'hABC);
        wait_trmt("t6b", t0 + 1, 200);
        tele_en = 1'b0;
        hd_pulses(8, 12'h5F0);
        wait_idle("t6b", 300);
        chk("t6b_trmt_count", n_trmt - t0, 3);

        // random traffic
        uart_rand = 1;
        tele_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            ack_req = ($urandom_range(0, 39) == 0);
            ack_byte = 8'($urandom);
            heading_rdy = ($urandom_range(0, 4) == 0);
            heading = 12'($urandom);
            if ($urandom_range(0, 299) == 0) tele_en = ~tele_en;
            @(negedge clk);
        end
        ack_req = 1'b0;
        heading_rdy = 1'b0;
        wait_idle("rand", 500);
        chk("end_byte_q_empty", byte_q.size(), 0);
        chk("end_sent_q_empty", sent_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
